// File: rtl/reg_redraw_scheduler_if.sv
// Row redraw request channel between the scheduler (master) and the register text drawer (slave).
interface reg_redraw_scheduler_if #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned REG_W = 32
);
    logic             row_valid;
    logic             row_ready;
    logic [IDX_W-1:0] row_idx;
    logic [REG_W-1:0] row_data;

    modport master (output row_valid, output row_idx, output row_data, input  row_ready);
    modport slave  (input  row_valid, input  row_idx, input  row_data, output row_ready);
endinterface

// File: rtl/reg_redraw_scheduler.sv
// Snapshots the register file, diffs it against the on-screen shadow copy and issues
// one redraw request per changed row, lowest index first, with a stable data payload.
module reg_redraw_scheduler #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_W    = 32,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REGS*REG_W-1:0] reg_flat,
    input  logic                      snap_req,
    input  logic                      force_all,
    reg_redraw_scheduler_if.master    row,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               update_count
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, COMPARE, ISSUE} state_t;

    state_t                             state, state_next;
    logic [NUM_REGS-1:0][REG_W-1:0]     capture, capture_next;
    logic [NUM_REGS-1:0][REG_W-1:0]     shadow, shadow_next;
    logic [NUM_REGS-1:0]                dirty, dirty_next;
    logic [NUM_REGS-1:0]                cmp_mask, remain;
    logic                               pending, pending_next;
    logic                               pend_force, pend_force_next;
    logic                               force_lat, force_lat_next;
    logic                               first_pass, first_pass_next;
    logic                               valid_q, valid_next;
    logic [IDX_W-1:0]                   idx_q, idx_next;
    logic [REG_W-1:0]                   data_q, data_next;
    logic                               busy_next, done_next;
    logic [CNT_W-1:0]                   count_next;
    logic                               handshake;

    // Lowest set bit position; rows are served in ascending order.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REGS-1:0] v);
        lowest = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    assign row.row_valid = valid_q;
    assign row.row_idx   = idx_q;
    assign row.row_data  = data_q;
    assign handshake     = valid_q & row.row_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            capture      <= '0;
            shadow       <= '0;
            dirty        <= '0;
            pending      <= 1'b0;
            pend_force   <= 1'b0;
            force_lat    <= 1'b0;
            first_pass   <= 1'b1;
            valid_q      <= 1'b0;
            idx_q        <= '0;
            data_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            update_count <= '0;
        end else begin
            state        <= state_next;
            capture      <= capture_next;
            shadow       <= shadow_next;
            dirty        <= dirty_next;
            pending      <= pending_next;
            pend_force   <= pend_force_next;
            force_lat    <= force_lat_next;
            first_pass   <= first_pass_next;
            valid_q      <= valid_next;
            idx_q        <= idx_next;
            data_q       <= data_next;
            busy         <= busy_next;
            done         <= done_next;
            update_count <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        capture_next    = capture;
        shadow_next     = shadow;
        dirty_next      = dirty;
        pending_next    = pending;
        pend_force_next = pend_force;
        force_lat_next  = force_lat;
        first_pass_next = first_pass;
        valid_next      = valid_q;
        idx_next        = idx_q;
        data_next       = data_q;
        done_next       = 1'b0;
        count_next      = update_count;

        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cmp_mask[i] = (capture[i] != shadow[i]) | force_lat | first_pass;
        end
        remain = dirty & ~(NUM_REGS'(1) << idx_q);

        case (state)
            IDLE: begin
                if (snap_req || pending) begin
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        capture_next[i] = reg_flat[REG_W*i +: REG_W];
                    end
                    force_lat_next  = (snap_req & force_all) | (pending & pend_force);
                    pending_next    = 1'b0;
                    pend_force_next = 1'b0;
                    state_next      = COMPARE;
                end
            end
            COMPARE: begin
                dirty_next      = cmp_mask;
                first_pass_next = 1'b0;
                if (|cmp_mask) begin
                    valid_next = 1'b1;
                    idx_next   = lowest(cmp_mask);
                    data_next  = capture[lowest(cmp_mask)];
                    state_next = ISSUE;
                end else begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    shadow_next[idx_q] = capture[idx_q];
                    dirty_next         = remain;
                    count_next         = (update_count == 16'hFFFF) ? update_count
                                                                    : update_count + 16'd1;
                    if (|remain) begin
                        idx_next  = lowest(remain);
                        data_next = capture[lowest(remain)];
                    end else begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase

        // Requests arriving mid-pass collapse into a single follow-up pass.
        if (state != IDLE && snap_req) begin
            pending_next    = 1'b1;
            pend_force_next = pend_force | force_all;
        end

        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_reg_redraw_scheduler.sv
// Directed bench for reg_redraw_scheduler: drives on negedges, samples on negedges.
module tb_reg_redraw_scheduler;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] reg_flat = '0;
    logic         snap_req = 1'b0;
    logic         force_all = 1'b0;
    logic         busy, done;
    logic [15:0]  update_count;

    reg_redraw_scheduler_if #(.IDX_W(3), .REG_W(32)) rif ();

    reg_redraw_scheduler #(.NUM_REGS(8), .REG_W(32), .IDX_W(3)) dut (
        .clock(clock), .reset(reset), .reg_flat(reg_flat), .snap_req(snap_req),
        .force_all(force_all), .row(rif), .busy(busy), .done(done),
        .update_count(update_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [31:0] regs [8];
    logic [2:0]  q_idx[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_q[$];
    logic [2:0]  exp_i[$];
    bit  saw_done, overlap;
    int  first_v, done_c;

    task automatic apply_regs();
        for (int i = 0; i < 8; i++) reg_flat[32*i +: 32] = regs[i];
    endtask

    task automatic snap(input logic f);
        @(negedge clock); snap_req = 1'b1; force_all = f;
        @(negedge clock); snap_req = 1'b0; force_all = 1'b0;
    endtask

    // Samples at the current negedge then advances; records accepted requests until done.
    task automatic run_pass(input int budget);
        q_idx.delete(); q_data.delete();
        saw_done = 0; overlap = 0; first_v = -1; done_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (rif.row_valid && done) overlap = 1;
            if (rif.row_valid && first_v < 0) first_v = c;
            if (rif.row_valid && rif.row_ready) begin
                q_idx.push_back(rif.row_idx); q_data.push_back(rif.row_data);
            end
            if (done) begin saw_done = 1; done_c = c; break; end
            @(negedge clock);
        end
    endtask

    task automatic check_pass(input string name);
        total++;
        if (!saw_done || overlap) begin
            bad++; $display("FAIL %s: done seen=%0d overlap=%0d required done=1 overlap=0", name, saw_done, overlap);
        end
        total++;
        if (q_idx.size() !== exp_i.size()) begin
            bad++; $display("FAIL %s count: got %0d required %0d", name, q_idx.size(), exp_i.size());
        end else begin
            for (int k = 0; k < exp_i.size(); k++) begin
                total++;
                if (q_idx[k] !== exp_i[k] || q_data[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL %s row %0d: got idx=%0d data=%h required idx=%0d data=%h",
                             name, k, q_idx[k], q_data[k], exp_i[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({rif.row_valid, rif.row_idx, rif.row_data, busy, done, update_count} !== '0) begin
            bad++; $display("FAIL reset: got valid=%b idx=%0d data=%h busy=%b done=%b cnt=%0d required all 0",
                            rif.row_valid, rif.row_idx, rif.row_data, busy, done, update_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_pass();
        for (int i = 0; i < 8; i++) regs[i] = 32'(i);
        apply_regs();
        rif.row_ready = 1'b1;
        snap(1'b0);
        total++;
        if (busy !== 1'b1 || rif.row_valid !== 1'b0) begin
            bad++; $display("FAIL compare_cycle: got busy=%b valid=%b required busy=1 valid=0", busy, rif.row_valid);
        end
        run_pass(30);
        exp_i.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin exp_i.push_back(3'(i)); exp_q.push_back(32'(i)); end
        check_pass("first_pass");
        total++;
        if (done_c - first_v !== 8 || busy !== 1'b0 || update_count !== 16'd8) begin
            bad++; $display("FAIL first_pass timing: got span=%0d busy=%b cnt=%0d required span=8 busy=0 cnt=8",
                            done_c - first_v, busy, update_count);
        end
    endtask

    task automatic test_single_change();
        regs[3] = 32'hAAAA0001; apply_regs();
        snap(1'b0);
        run_pass(30);
        exp_i = '{3'd3}; exp_q = '{32'hAAAA0001};
        check_pass("single_change");
        snap(1'b0);
        @(negedge clock);
        total++;
        if (done !== 1'b1 || rif.row_valid !== 1'b0) begin
            bad++; $display("FAIL no_change: got done=%b valid=%b required done=1 valid=0", done, rif.row_valid);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || update_count !== 16'd9) begin
            bad++; $display("FAIL no_change after: got done=%b cnt=%0d required done=0 cnt=9", done, update_count);
        end
    endtask

    task automatic test_stall();
        int errs = 0;
        rif.row_ready = 1'b0;
        regs[1] = 32'h11111111; regs[5] = 32'h55555555; apply_regs();
        snap(1'b0);
        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (rif.row_valid !== 1'b1 || rif.row_idx !== 3'd1 || rif.row_data !== 32'h11111111) begin
                bad++; errs++;
                $display("FAIL stall cycle %0d: got valid=%b idx=%0d data=%h required 1/1/11111111",
                         k, rif.row_valid, rif.row_idx, rif.row_data);
            end
            if (k == 3) begin regs[1] = 32'hDEADBEEF; apply_regs(); end
            @(negedge clock);
        end
        rif.row_ready = 1'b1;
        run_pass(20);
        exp_i = '{3'd1, 3'd5}; exp_q = '{32'h11111111, 32'h55555555};
        check_pass("stall_release");
        total++;
        if (update_count !== 16'd11) begin
            bad++; $display("FAIL stall count: got %0d required 11", update_count);
        end
    endtask

    task automatic test_force_all();
        snap(1'b1);
        run_pass(30);
        exp_i.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin exp_i.push_back(3'(i)); exp_q.push_back(regs[i]); end
        check_pass("force_all");
        total++;
        if (update_count !== 16'd19) begin
            bad++; $display("FAIL force_all count: got %0d required 19", update_count);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int d1 = -1;
        logic busy_after = 1'b0;
        q_idx.delete(); q_data.delete(); overlap = 0;
        exp_i.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin exp_i.push_back(3'(i)); exp_q.push_back(regs[i]); end
        snap(1'b1);
        for (int c = 0; c < 30; c++) begin
            if (rif.row_valid && done) overlap = 1;
            if (rif.row_valid && rif.row_ready) begin
                q_idx.push_back(rif.row_idx); q_data.push_back(rif.row_data);
            end
            if (done) begin dones++; if (d1 < 0) d1 = c; end
            if (d1 >= 0 && c == d1 + 1) busy_after = busy;
            snap_req = (c == 2 || c == 4);
            if (c == 3) begin regs[6] = 32'h66660066; apply_regs(); end
            @(negedge clock);
        end
        snap_req = 1'b0;
        exp_i.push_back(3'd6); exp_q.push_back(32'h66660066);
        saw_done = (dones > 0);
        check_pass("back_to_back");
        total++;
        if (dones !== 2 || busy_after !== 1'b1 || update_count !== 16'd28) begin
            bad++; $display("FAIL back_to_back: got dones=%0d busy_after=%b cnt=%0d required 2/1/28",
                            dones, busy_after, update_count);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        snap(1'b1);
        for (int c = 0; c < 20; c++) begin
            if (rif.row_valid && rif.row_idx == 3'd4) begin found = 1; break; end
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        total++;
        if (!found || {rif.row_valid, rif.row_idx, rif.row_data, busy, done, update_count} !== '0) begin
            bad++; $display("FAIL reset_mid: found=%0d valid=%b idx=%0d data=%h busy=%b done=%b cnt=%0d required all 0",
                            found, rif.row_valid, rif.row_idx, rif.row_data, busy, done, update_count);
        end
        @(negedge clock);
        reset = 1'b0;
        snap(1'b0);
        run_pass(30);
        exp_i.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin exp_i.push_back(3'(i)); exp_q.push_back(regs[i]); end
        check_pass("after_reset");
        total++;
        if (update_count !== 16'd8) begin
            bad++; $display("FAIL after_reset count: got %0d required 8", update_count);
        end
    endtask

    task automatic test_saturation();
        @(negedge clock);
        force dut.update_count = 16'hFFFD;
        repeat (2) @(negedge clock);
        release dut.update_count;
        snap(1'b1);
        run_pass(30);
        check_pass("saturation");
        total++;
        if (update_count !== 16'hFFFF) begin
            bad++; $display("FAIL saturation: got %h required ffff", update_count);
        end
    endtask

    initial begin
        rif.row_ready = 1'b0;
        #1;
        test_reset();
        test_first_pass();
        test_single_change();
        test_stall();
        test_force_all();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
